key_lane_sequencer: RTL
=======================

Name: key_lane_sequencer

Overview:
- Consumes the 1-cycle `tick` pulses from the scaling rate divider and advances a falling-note grid by one row per tick.
- Injects pseudo-random notes at the top row and judges player key presses against the bottom (hit) row.
- Outputs hit/miss events, score, miss count and game state to the VGA renderer and HUD.

Parameters:
- NUM_LANES, 4, number of key lanes (columns); must be 4 (lane index uses 2 LFSR bits).
- NUM_ROWS, 8, grid rows; row 0 is top, row NUM_ROWS-1 is the hit row.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.
- MISS_LIMIT, 3, miss count that ends the game (1..15).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  1-cycle advance pulse from the rate divider.
- key_press  input  NUM_LANES  debounced key levels, 1 = held.
- grid  output  NUM_LANES*NUM_ROWS  note map; bit r*NUM_LANES+l = note at row r, lane l.
- score  output  16  hit count, saturates at 16'hFFFF.
- miss_count  output  4  misses so far, saturates at MISS_LIMIT.
- hit_pulse  output  1  1-cycle pulse per cycle containing a hit.
- miss_pulse  output  1  1-cycle pulse per cycle containing any miss event.
- state  output  2  00 IDLE, 01 PLAY, 10 OVER.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values: grid=0, score=0, miss_count=0, hit_pulse=0, miss_pulse=0, state=IDLE, LFSR=LFSR_SEED, key edge register=0.
- Key edges: key_prev register; rise[l] = key_press[l] & ~key_prev[l]. key_prev updates every cycle in all states.

IDLE state:
- tick is ignored; grid stays 0.
- Any rise -> PLAY next cycle. That press is not judged.

PLAY state, evaluated in this order within one cycle, using pre-update register values:
1. Judge:
   - hit_lanes = rise & bottom_row.
   - wrong = |(rise & ~bottom_row).
   - Each hit lane's bottom note is cleared.
   - A row holds at most one note, so there is at most one hit per cycle.
2. Tick (if tick=1):
   - exit_miss = |(bottom_row & ~hit_lanes).
   - Shift all rows down by one.
   - New row 0 = (lfsr[2] ? one-hot(lfsr[1:0]) : 0).
   - LFSR advances once.
3. Score and miss accounting:
   - Any hit -> score+1 (saturating) and hit_pulse=1 next cycle.
   - wrong or exit_miss -> miss_count+1 (at most +1 per cycle, saturating) and miss_pulse=1 next cycle.
- A hit and a tick in the same cycle: the note is scored as a hit, the row still shifts, and no exit miss is counted for that note.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11; shifts left, feedback into bit 0.
- Advances only on tick in PLAY.

OVER state:
- Entered on the cycle miss_count becomes MISS_LIMIT.
- grid, score and miss_count freeze; tick and key_press are ignored.
- hit_pulse and miss_pulse stay 0.
- Only reset exits OVER.

Pulses: hit_pulse and miss_pulse are registered; they are high for exactly 1 cycle after the event cycle.

Reset mid-operation: on any cycle with reset=1, all state returns to reset values regardless of tick or keys that cycle.

Decomposition:
- Package key_lane_pkg: state encodings (ST_IDLE, ST_PLAY, ST_OVER), LFSR tap constant, LFSR width 16, score width 16.
- Sub-module lfsr16: ports clk, reset, en, seed parameter, q[15:0]. The rest stays in key_lane_sequencer.

Test Plan:
- Reset then 5 ticks with no keys -> state=IDLE, grid=0, LFSR output=16'hACE1.
- Press key 0 in IDLE, release, then 8 ticks -> state=PLAY. Grid rows match the bench LFSR model from seed ACE1. The first bottom-row note reaching exit with no press -> miss_pulse 1 cycle, miss_count=1.
- Note in lane 2 at bottom; rise on key 2 in the same cycle as tick -> hit_pulse=1, score=1, miss_count unchanged. The note does not reappear in the grid.
- Bottom row empty; rise on key 1 -> wrong press. miss_pulse=1, miss_count increments, score unchanged.
- Same cycle: wrong press on lane 0 plus unhit exit note on lane 3 -> miss_count increments by exactly 1.
- Drive 3 misses -> state=OVER on the third. Further ticks and presses leave grid, score and miss_count frozen. Reset asserted mid-OVER -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/key_lane_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_lane_pkg
//  Brief    : Shared types and constants for the key lane sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package key_lane_pkg;

  // Game state encoding, visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam int LFSR_W  = 16;
  localparam int SCORE_W = 16;

  // Feedback taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci step: shift left, XOR of the tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_lane_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_lane_sequencer_if
//  Brief    : Tick/key inputs and grid/score/status outputs of the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface key_lane_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int NUM_ROWS  = 8
) ();
  import key_lane_pkg::*;

  logic                           tick;
  logic [NUM_LANES-1:0]           key_press;
  logic [NUM_LANES*NUM_ROWS-1:0]  grid;
  logic [SCORE_W-1:0]             score;
  logic [3:0]                     miss_count;
  logic                           hit_pulse;
  logic                           miss_pulse;
  logic [1:0]                     state;

  // Driver side: rate divider, keypad and the renderer/HUD consuming results.
  modport master (
    output tick, key_press,
    input  grid, score, miss_count, hit_pulse, miss_pulse, state
  );

  // Sequencer side.
  modport slave (
    input  tick, key_press,
    output grid, score, miss_count, hit_pulse, miss_pulse, state
  );

endinterface
`default_nettype wire

// File: rtl/key_lane_sequencer_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16
//  Brief    : 16-bit Fibonacci LFSR with enable, reset to a fixed seed.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr16
  import key_lane_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;

  // Advance one step per enabled cycle; seed must be non-zero to avoid lock-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/key_lane_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : key_lane_sequencer
//  Brief    : Falling-note grid: injects random notes per tick, judges key
//             presses at the bottom row, keeps score and misses.
//  Revision : 1.0  initial release
// ============================================================================
module key_lane_sequencer
  import key_lane_pkg::*;
#(
  parameter int                NUM_LANES  = 4,
  parameter int                NUM_ROWS   = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter int                MISS_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  key_lane_sequencer_if.slave  bus
);

  localparam int         GRID_W   = NUM_LANES * NUM_ROWS;
  localparam logic [3:0] MISS_MAX = 4'(MISS_LIMIT);

  state_t                state_q,      state_d;
  logic [GRID_W-1:0]     grid_q,       grid_d;
  logic [SCORE_W-1:0]    score_q,      score_d;
  logic [3:0]            miss_q,       miss_d;
  logic                  hit_pulse_q,  hit_pulse_d;
  logic                  miss_pulse_q, miss_pulse_d;
  logic [NUM_LANES-1:0]  key_prev_q;

  logic [LFSR_W-1:0]     w_lfsr;
  logic                  w_lfsr_en;
  logic [NUM_LANES-1:0]  w_rise;
  logic [NUM_LANES-1:0]  w_bottom;
  logic [NUM_LANES-1:0]  w_hit_lanes;
  logic [NUM_LANES-1:0]  w_new_row;
  logic [GRID_W-1:0]     w_grid_judged;
  logic                  w_any_hit;
  logic                  w_wrong;
  logic                  w_exit_miss;
  logic                  w_miss_event;
  logic                  unused_lfsr_hi;

  // Random note source; only steps when a row actually advances during play.
  assign w_lfsr_en = (state_q == ST_PLAY) && bus.tick;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (w_lfsr_en),
    .q     (w_lfsr)
  );

  // Only the low three bits choose lane and note presence.
  assign unused_lfsr_hi = ^w_lfsr[LFSR_W-1:3];

  // Judge against the bottom row as it stood before this cycle's update.
  assign w_rise        = bus.key_press & ~key_prev_q;
  assign w_bottom      = grid_q[GRID_W-1 -: NUM_LANES];
  assign w_hit_lanes   = w_rise & w_bottom;
  assign w_any_hit     = |w_hit_lanes;
  assign w_wrong       = |(w_rise & ~w_bottom);
  assign w_grid_judged = grid_q & ~{w_hit_lanes, {(GRID_W-NUM_LANES){1'b0}}};

  // A note leaving the grid on a tick is a miss unless it was hit this cycle.
  assign w_exit_miss   = bus.tick & (|(w_bottom & ~w_hit_lanes));
  assign w_miss_event  = w_wrong | w_exit_miss;
  assign w_new_row     = w_lfsr[2] ? (NUM_LANES'(1) << w_lfsr[1:0]) : '0;

  // Register update; reset overrides every input in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grid_q       <= '0;
      score_q      <= '0;
      miss_q       <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      key_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      grid_q       <= grid_d;
      score_q      <= score_d;
      miss_q       <= miss_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      key_prev_q   <= bus.key_press;
    end
  end

  // Game FSM with grid shift and saturating score/miss accounting.
  always_comb begin
    state_d      = state_q;
    grid_d       = grid_q;
    score_d      = score_q;
    miss_d       = miss_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The starting press only starts the game; it is never judged.
        if (|w_rise) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        grid_d = bus.tick ? {w_grid_judged[GRID_W-NUM_LANES-1:0], w_new_row}
                          : w_grid_judged;
        if (w_any_hit) begin
          hit_pulse_d = 1'b1;
          if (score_q != '1) begin
            score_d = score_q + 1'b1;
          end
        end
        // Wrong press and exit miss together still cost a single miss.
        if (w_miss_event) begin
          miss_pulse_d = 1'b1;
          if (miss_q != MISS_MAX) begin
            miss_d = miss_q + 1'b1;
          end
          if (miss_d == MISS_MAX) begin
            state_d = ST_OVER;
          end
        end
      end
      ST_OVER: begin
        // Everything holds until reset.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.state      = state_q;
  assign bus.grid       = grid_q;
  assign bus.score      = score_q;
  assign bus.miss_count = miss_q;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.miss_pulse = miss_pulse_q;

endmodule
`default_nettype wire
